glb_pe_mc: RTL

- Next-generation global processing element for the convolution array: single-clock, parametrised successor to the multicaster + CCD buffer + PE wrapper.
- Receives tagged words from the global X-bus and accepts those matching its locked tag or the broadcast tag.
- Steers accepted words into per-channel FIFOs (ifmap, filter, psum).
- Runs a kernel-length MAC sequence, seeded with an incoming psum, and emits the updated psum over a valid/ready port.

---
 rtl/glb_pe_pkg.sv | 30 +++
 rtl/glb_pe_mc_if.sv | 28 ++
 rtl/glb_pe_fifo.sv | 61 ++++++
 rtl/glb_pe_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/glb_pe_pkg.sv
// Shared types and constant helpers for the global PE multicaster.
// Holds channel/state enums plus tag-width and broadcast-tag functions.
package glb_pe_pkg;

    typedef enum logic [1:0] {
        CH_IFMAP = 2'd0,
        CH_FILT  = 2'd1,
        CH_PSUM  = 2'd2,
        CH_RSVD  = 2'd3
    } ch_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam int NUM_FIFO = 3;

    function automatic int tag_w(input int num_col);
        return $clog2(num_col) + 1;
    endfunction

    // All-ones tag of the bus width addresses every column at once.
    function automatic int bcast_tag(input int num_col);
        return (1 << tag_w(num_col)) - 1;
    endfunction

endpackage

// File: rtl/glb_pe_mc_if.sv
// X-bus input and psum output handshake bundle of the global PE.
// slave = PE side, master = bus/downstream side.
interface glb_pe_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_W      = 3
) ();

    logic                  bus_valid;
    logic                  bus_ready;
    logic [TAG_W-1:0]      bus_tag;
    logic [1:0]            bus_ch;
    logic [DATA_WIDTH-1:0] bus_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  bus_valid, bus_tag, bus_ch, bus_data, out_ready,
        output bus_ready, out_valid, out_data
    );

    modport master (
        output bus_valid, bus_tag, bus_ch, bus_data, out_ready,
        input  bus_ready, out_valid, out_data
    );

endinterface

// File: rtl/glb_pe_fifo.sv
// Synchronous show-ahead FIFO used for each PE operand channel.
// Head word is visible on o_data whenever o_empty is low.
module glb_pe_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/glb_pe_mc.sv
// Global PE: tag-filtered X-bus intake, per-channel FIFOs, kernel MAC, psum out.
// Optional macro GLB_PE_SAT_EN: saturating out_data plus sticky sat_flag port.
module glb_pe_mc
    import glb_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_KLEN   = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8,
    localparam int TAG_W  = tag_w(NUM_COL),
    localparam int KLEN_W = $clog2(MAX_KLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [TAG_W-1:0]  cfg_tag,
    input  logic [KLEN_W-1:0] cfg_klen,
    output logic              tag_lock,
    glb_pe_mc_if.slave        bus,
    output logic              busy
`ifdef GLB_PE_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [TAG_W-1:0] BCAST = TAG_W'(bcast_tag(NUM_COL));
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int C_IF  = int'(CH_IFMAP);
    localparam int C_FI  = int'(CH_FILT);
    localparam int C_PS  = int'(CH_PSUM);

    state_e                       r_state;
    logic [TAG_W-1:0]             r_tag;
    logic [KLEN_W-1:0]            r_klen;
    logic                         r_tag_lock;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [KLEN_W-1:0]            r_cnt;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_out_data;

    logic                         w_push    [NUM_FIFO];
    logic                         w_pop     [NUM_FIFO];
    logic                         w_full    [NUM_FIFO];
    logic                         w_empty   [NUM_FIFO];
    logic [DATA_WIDTH-1:0]        w_rd_data [NUM_FIFO];
    logic [CNT_W-1:0]             w_count   [NUM_FIFO];

    logic                         w_match;
    logic                         w_bus_ready;
    logic                         w_mac_fire;
    logic [KLEN_W-1:0]            w_klen_eff;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_psum_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic signed [ACC_WIDTH-1:0]  w_shift;
    logic [DATA_WIDTH-1:0]        w_res;

    assign w_match = r_tag_lock && ((bus.bus_tag == r_tag) || (bus.bus_tag == BCAST));

    // Unmatched and reserved-channel words are always taken so other columns never stall.
    always_comb begin
        w_bus_ready = 1'b1;
        if (w_match) begin
            case (ch_e'(bus.bus_ch))
                CH_IFMAP: w_bus_ready = !w_full[C_IF];
                CH_FILT:  w_bus_ready = !w_full[C_FI];
                CH_PSUM:  w_bus_ready = !w_full[C_PS];
                default:  w_bus_ready = 1'b1;
            endcase
        end
    end

    assign w_mac_fire = (r_state == MAC) && !w_empty[C_IF] && !w_empty[C_FI];

    always_comb begin
        w_pop[C_IF] = w_mac_fire;
        w_pop[C_FI] = w_mac_fire;
        w_pop[C_PS] = (r_state == LOAD);
    end

    generate
        for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_fifo
            assign w_push[gi] = bus.bus_valid && w_match && (bus.bus_ch == 2'(gi)) && !w_full[gi];

            glb_pe_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[gi]),
                .i_data  (bus.bus_data),
                .i_pop   (w_pop[gi]),
                .o_data  (w_rd_data[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi]),
                .o_count (w_count[gi])
            );
        end
    endgenerate

    wire w_unused_count = ^{w_count[0], w_count[1], w_count[2]};

    always_comb begin
        w_klen_eff = cfg_klen;
        if (cfg_klen == '0) begin
            w_klen_eff = KLEN_W'(1);
        end else if (cfg_klen > KLEN_W'(MAX_KLEN)) begin
            w_klen_eff = KLEN_W'(MAX_KLEN);
        end
    end

    assign w_prod     = $signed(w_rd_data[C_IF]) * $signed(w_rd_data[C_FI]);
    assign w_psum_ext = {{(ACC_WIDTH-DATA_WIDTH){w_rd_data[C_PS][DATA_WIDTH-1]}}, w_rd_data[C_PS]};
    assign w_acc_next = r_acc + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_shift    = w_acc_next >>> FRAC_BITS;

`ifdef GLB_PE_SAT_EN
    logic w_ovf;
    logic r_sat;

    // In range only when every bit above the result sign bit copies it.
    assign w_ovf = !((&w_shift[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|w_shift[ACC_WIDTH-1:DATA_WIDTH-1]));
    assign w_res = !w_ovf ? w_shift[DATA_WIDTH-1:0] :
                   w_shift[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                          {1'b0, {(DATA_WIDTH-1){1'b1}}};
    assign sat_flag = r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_mac_fire && (r_cnt == r_klen - KLEN_W'(1)) && w_ovf) begin
            r_sat <= 1'b1;
        end
    end
`else
    assign w_res = w_shift[DATA_WIDTH-1:0];
    wire w_unused_shift = ^w_shift[ACC_WIDTH-1:DATA_WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_klen      <= '0;
            r_tag_lock  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_tag      <= cfg_tag;
                        r_klen     <= w_klen_eff;
                        r_tag_lock <= 1'b1;
                    end
                    if (r_tag_lock && !w_empty[C_PS]) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_acc   <= w_psum_ext << FRAC_BITS;
                    r_cnt   <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    if (w_mac_fire) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + KLEN_W'(1);
                        // Result is registered on the final pop so out_data is stable in OUT.
                        if (r_cnt == r_klen - KLEN_W'(1)) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tag_lock      = r_tag_lock;
    assign busy          = (r_state != IDLE);
    assign bus.bus_ready = w_bus_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule
